// File: rtl/fpu_pkg.sv
// Shared FPU constants and stage-register types.
// Used by the float-to-int pipeline and its alignment sub-block.
package fpu_pkg;

    localparam logic [7:0]  FP_BIAS   = 8'd127;
    localparam logic [7:0]  FTOI_EMAX = 8'd158;
    localparam logic [31:0] INT32_MAX = 32'h7FFFFFFF;
    localparam logic [31:0] INT32_MIN = 32'h80000000;

    typedef enum logic {
        RND_NE = 1'b0,
        RND_TZ = 1'b1
    } rnd_mode_t;

    // Stage-1 contents: aligned integer part plus rounding and saturation info.
    typedef struct packed {
        logic        sign;
        logic        sat;
        logic        sat_neg;
        logic        inv;
        logic [31:0] int_part;
        logic        guard;
        logic        sticky;
        rnd_mode_t   mode;
    } ftoi_s1_t;

endpackage

// File: rtl/fpu_ftoi_align.sv
// Stage-1 logic of the float-to-int converter: unpack, shift the significand
// into integer position and extract guard/sticky and saturation information.
module fpu_ftoi_align
    import fpu_pkg::*;
(
    input  logic                         x_i,
    input  logic [31:0]                  x_bits_i,
    input  logic                         mode_i,
    output logic [$bits(ftoi_s1_t)-1:0]  s1_o
);

    logic        sign;
    logic [7:0]  exp_b;
    logic [22:0] man;
    logic [7:0]  sh;
    logic [54:0] f;
    ftoi_s1_t    s1;

    assign sign  = x_bits_i[31];
    assign exp_b = x_bits_i[30:23];
    assign man   = x_bits_i[22:0];
    assign sh    = exp_b - FP_BIAS;
    assign f     = {31'b0, 1'b1, man} << sh;

    always_comb begin
        s1      = '0;
        s1.sign = sign;
        s1.mode = rnd_mode_t'(mode_i);
        if (exp_b >= FTOI_EMAX) begin
            // NaN always saturates positive; only exactly -2^31 is representable.
            s1.sat     = 1'b1;
            s1.sat_neg = sign & !((exp_b == 8'hFF) && (man != '0));
            s1.inv     = !(sign && (exp_b == FTOI_EMAX) && (man == '0));
        end else if (exp_b >= FP_BIAS) begin
            s1.int_part = f[54:23];
            s1.guard    = f[22];
            s1.sticky   = |f[21:0];
        end else if (exp_b == (FP_BIAS - 8'd1)) begin
            s1.guard  = 1'b1;
            s1.sticky = |man;
        end
    end

    assign s1_o = s1 & {$bits(ftoi_s1_t){x_i}};

endmodule

// File: rtl/fpu_ftoi.sv
// Two-stage elastic float-to-int converter: align in stage 1, round/negate and
// saturate in stage 2. Each stage register advances when it is empty or drains.
module fpu_ftoi
    import fpu_pkg::*;
#(
    parameter int TAG_W = 6
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      x,
    input  logic             mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      y,
    output logic [TAG_W-1:0] out_tag,
    output logic             invalid
);

    logic             adv1, adv2;
    logic             v1_q, v2_q;
    ftoi_s1_t         s1_d, s1_q;
    logic [TAG_W-1:0] tag1_q, tag2_q;
    logic [31:0]      y_d, y_q;
    logic             inv_q;
    logic             inc;
    logic [31:0]      mag;

    fpu_ftoi_align u_align (
        .x_i      (1'b1),
        .x_bits_i (x),
        .mode_i   (mode),
        .s1_o     (s1_d)
    );

    assign adv2     = !v2_q || out_ready;
    assign adv1     = !v1_q || adv2;
    assign in_ready = adv1;

    assign inc = (s1_q.mode == RND_NE) && s1_q.guard && (s1_q.sticky || s1_q.int_part[0]);
    assign mag = s1_q.int_part + {31'b0, inc};

    always_comb begin
        y_d = s1_q.sign ? (~mag + 32'd1) : mag;
        if (s1_q.sat) begin
            y_d = s1_q.sat_neg ? INT32_MIN : INT32_MAX;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            s1_q   <= '0;
            tag1_q <= '0;
            tag2_q <= '0;
            y_q    <= '0;
            inv_q  <= 1'b0;
        end else begin
            if (adv1) begin
                v1_q   <= in_valid;
                s1_q   <= s1_d;
                tag1_q <= in_tag;
            end
            if (adv2) begin
                v2_q   <= v1_q;
                y_q    <= y_d;
                tag2_q <= tag1_q;
                inv_q  <= s1_q.inv;
            end
        end
    end

    assign out_valid = v2_q;
    assign y         = y_q;
    assign out_tag   = tag2_q;
    assign invalid   = inv_q;

endmodule
